// File: rtl/pipe_skid_register.sv
// pipe_skid_register: valid/ready pipeline stage with 2-entry skid buffer and synchronous flush.
// Define PIPE_SKID_STAT_EN to add the saturating upstream stall counter (stall_cnt).
module pipe_skid_register #(
  parameter int WIDTH = 150,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}},
  parameter int CNT_WIDTH = 16
) (
  input  logic             clk,
  input  logic             areset,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [1:0]       occupancy
`ifdef PIPE_SKID_STAT_EN
  ,
  output logic [CNT_WIDTH-1:0] stall_cnt
`endif
);
  logic [WIDTH-1:0] main_data, skid_data;
  logic main_valid, skid_valid, in_fire, out_fire;
  assign in_ready  = !skid_valid && areset;
  assign out_valid = main_valid;
  assign out_data  = main_data;
  assign occupancy = {1'b0, main_valid} + {1'b0, skid_valid};
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = main_valid && out_ready;
  // skid_valid implies main_valid, so the three branches cover EMPTY, FULL and HALF
  always_ff @(posedge clk or negedge areset)
    if (!areset) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_data  <= RESET_VALUE;
      skid_data  <= RESET_VALUE;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (!main_valid) begin
      if (in_fire) begin
        main_data  <= in_data;
        main_valid <= 1'b1;
      end
    end else if (skid_valid) begin
      if (out_fire) begin
        main_data  <= skid_data;
        skid_valid <= 1'b0;
      end
    end else if (in_fire && out_fire)
      main_data <= in_data;
    else if (in_fire) begin
      skid_data  <= in_data;
      skid_valid <= 1'b1;
    end else if (out_fire)
      main_valid <= 1'b0;
`ifdef PIPE_SKID_STAT_EN
  always_ff @(posedge clk or negedge areset)
    if (!areset)
      stall_cnt <= '0;
    else if (in_valid && !in_ready && stall_cnt != '1)
      stall_cnt <= stall_cnt + CNT_WIDTH'(1);
`endif
endmodule

// File: doc/pipe_skid_register.md
Name: pipe_skid_register

Overview:
- Parametrised pipeline stage register. Generalises the fixed-width enable register into a WIDTH-bit stage with valid/ready handshake, a 2-entry skid buffer and synchronous flush.
- Sits between processor pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Sustains one transfer per cycle under back-pressure, with a registered in_ready.

Parameters:
- WIDTH, 150, payload width in bits.
- RESET_VALUE, {WIDTH{1'b0}}, value loaded into both data registers on reset.
- CNT_WIDTH, 16, width of the stall counter. Used only with PIPE_SKID_STAT_EN.

Ports:
- clk  in  1  rising-edge clock.
- areset  in  1  asynchronous reset, active-low (0 = reset).
- flush  in  1  synchronous pipeline flush, active-high.
- in_valid  in  1  upstream payload valid.
- in_data  in  WIDTH  upstream payload.
- in_ready  out  1  stage can accept a payload.
- out_valid  out  1  stage holds a valid payload.
- out_data  out  WIDTH  payload presented downstream.
- out_ready  in  1  downstream accepts the payload (0 = stall).
- occupancy  out  2  number of valid entries, 0..2.
- stall_cnt  out  CNT_WIDTH  upstream stall cycles. Present only with PIPE_SKID_STAT_EN.

Behaviour:
- Storage:
  - main entry: main_data, main_valid.
  - skid entry: skid_data, skid_valid.
- Outputs:
  - out_data = main_data, out_valid = main_valid.
  - in_ready = !skid_valid && areset. Forced 0 while reset is asserted.
  - occupancy = main_valid + skid_valid.
- Transfer definitions:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
- Reset (areset=0, asynchronous):
  - main_valid = skid_valid = 0.
  - main_data = skid_data = RESET_VALUE.
  - out_valid = 0, out_data = RESET_VALUE, occupancy = 0, in_ready = 0.
  - On deassertion, in_ready = 1 in the same cycle. First capture happens at the next rising edge.
- States, derived from (main_valid, skid_valid):
  - EMPTY (0,0)
  - HALF (1,0)
  - FULL (1,1)
  - (0,1) is illegal and never reached.
- Transitions, at the rising edge, when flush=0:
  - EMPTY: in_fire → main<=in_data, go to HALF. out_ready is ignored.
  - HALF, in_fire & out_fire → main<=in_data, stay HALF (full-throughput pass).
  - HALF, in_fire & !out_fire → skid<=in_data, go to FULL.
  - HALF, !in_fire & out_fire → go to EMPTY. main_data holds its old value.
  - HALF, neither → hold.
  - FULL: in_ready=0, so in_fire is impossible.
  - FULL, out_fire → main<=skid_data, go to HALF.
  - FULL, !out_fire → hold.
- Latency and ordering:
  - 1 cycle from in_fire to out_valid when the stage is EMPTY.
  - Payloads leave in strict arrival order.
  - No payload is lost or duplicated.
- Flush:
  - Highest priority of the synchronous events.
  - At the edge: main_valid = skid_valid = 0, go to EMPTY.
  - Any in_fire or out_fire in the same cycle is discarded: no capture, upstream handshake counts as consumed.
  - Data registers keep their values.
- Data registers update only on the capture events listed above. out_data is stable whenever out_valid=1 and out_ready=0.
- Reset asserted mid-operation: immediate return to reset values, regardless of clk.

Optional Feature:
- Macro: PIPE_SKID_STAT_EN.
- Defined:
  - stall_cnt port exists.
  - Increments by 1 on each rising edge where in_valid=1 and in_ready=0.
  - Saturates at all-ones.
  - Reset to 0 by areset only; flush does not clear it.
- Undefined:
  - No stall_cnt port, no counter logic.
  - All other behaviour is identical.

Test Plan:
- Reset, then deassert → out_valid=0, out_data=RESET_VALUE, occupancy=0, in_ready=1.
- Streaming: out_ready=1, in_valid=1 for 8 cycles, payloads 1..8 → out_data=1..8 on consecutive cycles starting 1 cycle after the first fire; occupancy stays 1; in_ready stays 1.
- Back-pressure: send A, B with out_ready=0 → occupancy=2 and in_ready=0 after B. Raise out_ready → A, then B emitted on successive cycles; in_ready=1 one cycle after A leaves.
- Flush while FULL with in_valid=1, payload C → next cycle out_valid=0, occupancy=0, in_ready=1; C is never emitted.
- Async reset mid-FULL, asserted between clock edges → out_valid and occupancy drop to 0 immediately; out_data=RESET_VALUE.
- PIPE_SKID_STAT_EN with CNT_WIDTH=4: hold in_valid=1, out_ready=0 for 20 cycles → stall_cnt saturates at 15; remains 15 after a flush; returns to 0 on reset.
